cam_lvds_tx_framer: RTL and testbench



---
 rtl/cam_lvds_pkg.sv | 21 ++
 rtl/cam_tx_ramp_gen.sv | 20 ++
 rtl/cam_lvds_tx_framer.sv | 175 +++++++++++++++++
 tb/tb_cam_lvds_tx_framer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/cam_lvds_pkg.sv
// Shared constants and types for the camera LVDS transmit framer and its receive-side checker.
package cam_lvds_pkg;

    localparam int unsigned LANES  = 4;
    localparam int unsigned LANE_W = 8;

    localparam logic [7:0] TR  = 8'h3A;
    localparam logic [7:0] FS  = 8'hAA;
    localparam logic [7:0] LS  = 8'h2A;
    localparam logic [7:0] IMG = 8'h0D;
    localparam logic [7:0] LE  = 8'h12;
    localparam logic [7:0] FE  = 8'hCA;

    typedef enum logic [1:0] {
        StIdle,
        StActive,
        StHblank,
        StVblank
    } state_e;

endpackage

// File: rtl/cam_tx_ramp_gen.sv
// Combinational ramp pattern: lane k = (4*col + k + row) mod 256.
module cam_tx_ramp_gen
    import cam_lvds_pkg::*;
#(
    parameter int unsigned COL_W = 10,
    parameter int unsigned ROW_W = 11
) (
    input  logic [COL_W-1:0]        col,
    input  logic [ROW_W-1:0]        row,
    output logic [LANES*LANE_W-1:0] data
);

    always_comb begin
        data = '0;
        for (int k = 0; k < LANES; k++) begin
            data[k*LANE_W +: LANE_W] = LANE_W'({col, 2'b00}) + LANE_W'(k) + LANE_W'(row);
        end
    end

endmodule

// File: rtl/cam_lvds_tx_framer.sv
// Imager emulator: frames ramp or streamed pixels into sync + 4 data lanes for the LVDS serializer.
module cam_lvds_tx_framer
    import cam_lvds_pkg::*;
#(
    parameter int unsigned COL_W       = 10,
    parameter int unsigned ROW_W       = 11,
    parameter int unsigned BLANK_W     = 12,
    parameter bit          INVERT_DATA = 1'b0
) (
    input  logic               c,
    input  logic               rst,
    input  logic               en,
    input  logic               pattern_sel,
    input  logic [COL_W-1:0]   cols,
    input  logic [ROW_W-1:0]   rows,
    input  logic [BLANK_W-1:0] hblank,
    input  logic [BLANK_W-1:0] vblank,
    input  logic [31:0]        pix_d,
    input  logic               pix_valid,
    output logic               pix_ready,
    output logic [39:0]        txd,
    output logic               busy,
    output logic               underflow,
    input  logic               clr_underflow,
    output logic [15:0]        frame_count
);

    localparam logic [31:0] InvMask = {32{INVERT_DATA}};

    state_e             state_q, state_d;
    logic [COL_W-1:0]   col_q, col_d, cols_q, cols_d;
    logic [ROW_W-1:0]   row_q, row_d, rows_q, rows_d;
    logic [BLANK_W-1:0] cnt_q, cnt_d, hblank_q, hblank_d, vblank_q, vblank_d;
    logic [39:0]        txd_q;
    logic               underflow_q;
    logic [15:0]        frame_count_q;

    logic        last_col, last_row, frame_edge;
    logic [7:0]  sync_word;
    logic [31:0] data_word, ramp_data;
    logic        underflow_set, fc_inc;

    assign last_col = (col_q == cols_q - COL_W'(1));
    assign last_row = (row_q == rows_q - ROW_W'(1));

    cam_tx_ramp_gen #(
        .COL_W(COL_W),
        .ROW_W(ROW_W)
    ) u_ramp (
        .col (col_q),
        .row (row_q),
        .data(ramp_data)
    );

    always_ff @(posedge c) begin
        if (rst) begin
            state_q  <= StIdle;
            col_q    <= '0;
            row_q    <= '0;
            cnt_q    <= '0;
            cols_q   <= '0;
            rows_q   <= '0;
            hblank_q <= '0;
            vblank_q <= '0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            row_q    <= row_d;
            cnt_q    <= cnt_d;
            cols_q   <= cols_d;
            rows_q   <= rows_d;
            hblank_q <= hblank_d;
            vblank_q <= vblank_d;
        end
    end

    // frame_edge: a frame boundary (IDLE or end of VBLANK) where en decides restart vs idle.
    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        cnt_d      = cnt_q;
        cols_d     = cols_q;
        rows_d     = rows_q;
        hblank_d   = hblank_q;
        vblank_d   = vblank_q;
        frame_edge = 1'b0;
        unique case (state_q)
            StIdle: frame_edge = 1'b1;
            StActive: begin
                if (last_col) begin
                    col_d = '0;
                    cnt_d = '0;
                    if (last_row) begin
                        if (vblank_q == '0) frame_edge = 1'b1;
                        else                state_d    = StVblank;
                    end else if (hblank_q == '0) begin
                        row_d = row_q + ROW_W'(1);
                    end else begin
                        state_d = StHblank;
                    end
                end else begin
                    col_d = col_q + COL_W'(1);
                end
            end
            StHblank: begin
                if (cnt_q == hblank_q - BLANK_W'(1)) begin
                    cnt_d   = '0;
                    row_d   = row_q + ROW_W'(1);
                    state_d = StActive;
                end else begin
                    cnt_d = cnt_q + BLANK_W'(1);
                end
            end
            StVblank: begin
                if (cnt_q == vblank_q - BLANK_W'(1)) frame_edge = 1'b1;
                else                                  cnt_d      = cnt_q + BLANK_W'(1);
            end
            default: state_d = StIdle;
        endcase
        if (frame_edge) begin
            col_d   = '0;
            row_d   = '0;
            cnt_d   = '0;
            state_d = StIdle;
            if (en) begin
                state_d  = StActive;
                cols_d   = (cols < COL_W'(2)) ? COL_W'(2) : cols;
                rows_d   = (rows == '0) ? ROW_W'(1) : rows;
                hblank_d = hblank;
                vblank_d = vblank;
            end
        end
    end

    always_comb begin
        sync_word     = TR;
        data_word     = '0;
        pix_ready     = 1'b0;
        underflow_set = 1'b0;
        fc_inc        = 1'b0;
        if (state_q == StActive) begin
            sync_word = IMG;
            if (col_q == '0) sync_word = (row_q == '0) ? FS : LS;
            if (last_col)    sync_word = last_row ? FE : LE;
            fc_inc    = last_col && last_row;
            pix_ready = !pattern_sel;
            if (pattern_sel) begin
                data_word = ramp_data;
            end else begin
                data_word     = pix_valid ? pix_d : 32'h0;
                underflow_set = !pix_valid;
            end
        end
    end

    always_ff @(posedge c) begin
        if (rst) begin
            txd_q         <= {TR, InvMask};
            underflow_q   <= 1'b0;
            frame_count_q <= '0;
        end else begin
            txd_q <= {sync_word, data_word ^ InvMask};
            if (underflow_set)      underflow_q <= 1'b1;
            else if (clr_underflow) underflow_q <= 1'b0;
            if (fc_inc) frame_count_q <= frame_count_q + 16'd1;
        end
    end

    assign txd         = txd_q;
    assign busy        = (state_q != StIdle);
    assign underflow   = underflow_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_cam_lvds_tx_framer.sv
// Directed bench for cam_lvds_tx_framer: ramp frame table plus clamp, stream, en-drop and reset cases.
module tb_cam_lvds_tx_framer;
    import cam_lvds_pkg::*;

    logic        c, rst, en, pattern_sel, pix_valid, clr_underflow;
    logic [9:0]  cols;
    logic [10:0] rows;
    logic [11:0] hblank, vblank;
    logic [31:0] pix_d;
    logic        pix_ready, busy, underflow;
    logic [39:0] txd;
    logic [15:0] frame_count;
    logic        pix_ready_i, busy_i, underflow_i;
    logic [39:0] txd_i;
    logic [15:0] frame_count_i;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0]  sync;
        logic [31:0] data;
        logic [15:0] fc;
    } vec_t;
    vec_t vecs[13];

    cam_lvds_tx_framer #(.INVERT_DATA(1'b0)) dut (
        .c(c), .rst(rst), .en(en), .pattern_sel(pattern_sel), .cols(cols), .rows(rows),
        .hblank(hblank), .vblank(vblank), .pix_d(pix_d), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .txd(txd), .busy(busy), .underflow(underflow),
        .clr_underflow(clr_underflow), .frame_count(frame_count)
    );

    cam_lvds_tx_framer #(.INVERT_DATA(1'b1)) dut_inv (
        .c(c), .rst(rst), .en(en), .pattern_sel(pattern_sel), .cols(cols), .rows(rows),
        .hblank(hblank), .vblank(vblank), .pix_d(pix_d), .pix_valid(pix_valid),
        .pix_ready(pix_ready_i), .txd(txd_i), .busy(busy_i), .underflow(underflow_i),
        .clr_underflow(clr_underflow), .frame_count(frame_count_i)
    );

    initial c = 1'b0;
    always #5 c = ~c;

    task automatic tick();
        @(posedge c);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic set_vec(input int i, input logic [7:0] s, input logic [31:0] d,
                           input logic [15:0] f);
        vecs[i].sync = s;
        vecs[i].data = d;
        vecs[i].fc   = f;
    endtask

    initial begin
        int n_ls, n_le, n_fe;
        bit done;

        rst = 1'b1; en = 1'b0; pattern_sel = 1'b1; pix_valid = 1'b0; clr_underflow = 1'b0;
        cols = 10'd3; rows = 11'd2; hblank = 12'd2; vblank = 12'd3; pix_d = '0;

        set_vec(0,  TR,  32'h00000000, 16'd0);
        set_vec(1,  FS,  32'h03020100, 16'd0);
        set_vec(2,  IMG, 32'h07060504, 16'd0);
        set_vec(3,  LE,  32'h0B0A0908, 16'd0);
        set_vec(4,  TR,  32'h00000000, 16'd0);
        set_vec(5,  TR,  32'h00000000, 16'd0);
        set_vec(6,  LS,  32'h04030201, 16'd0);
        set_vec(7,  IMG, 32'h08070605, 16'd0);
        set_vec(8,  FE,  32'h0C0B0A09, 16'd1);
        set_vec(9,  TR,  32'h00000000, 16'd1);
        set_vec(10, TR,  32'h00000000, 16'd1);
        set_vec(11, TR,  32'h00000000, 16'd1);
        set_vec(12, FS,  32'h03020100, 16'd1);

        // Reset state
        tick(); tick();
        chk("rst_txd", 64'(txd), {24'h0, TR, 32'h0});
        chk("rst_txd_inv", 64'(txd_i), {24'h0, TR, 32'hFFFFFFFF});
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_underflow", 64'(underflow), 64'd0);
        chk("rst_fc", 64'(frame_count), 64'd0);
        chk("rst_pix_ready", 64'(pix_ready), 64'd0);

        // Ramp frame 3x2, hblank 2, vblank 3
        rst = 1'b0; en = 1'b1;
        for (int i = 0; i < 13; i++) begin
            tick();
            chk($sformatf("ramp_sync[%0d]", i), 64'(txd[39:32]), 64'(vecs[i].sync));
            chk($sformatf("ramp_data[%0d]", i), 64'(txd[31:0]), 64'(vecs[i].data));
            chk($sformatf("ramp_fc[%0d]", i), 64'(frame_count), 64'(vecs[i].fc));
            if (i == 1) chk("inv_first_word", 64'(txd_i), {24'h0, FS, 32'hFCFDFEFF});
        end
        chk("ramp_busy", 64'(busy), 64'd1);
        chk("ramp_no_underflow", 64'(underflow), 64'd0);

        // Clamped config: cols 0 -> 2, rows 0 -> 1
        rst = 1'b1; tick();
        rst = 1'b0; cols = 10'd0; rows = 11'd0; hblank = 12'd0; vblank = 12'd1;
        tick();
        tick();
        chk("clamp_fs", 64'(txd), {24'h0, FS, 32'h03020100});
        en = 1'b0;
        tick();
        chk("clamp_fe", 64'(txd), {24'h0, FE, 32'h07060504});
        chk("clamp_fc", 64'(frame_count), 64'd1);
        tick();
        chk("clamp_vblank", 64'(txd), {24'h0, TR, 32'h0});
        chk("clamp_idle", 64'(busy), 64'd0);

        // Stream mode with an underflow on the 2nd word
        rst = 1'b1; tick();
        rst = 1'b0; pattern_sel = 1'b0; cols = 10'd4; rows = 11'd1; vblank = 12'd2;
        en = 1'b1;
        tick();
        chk("stream_ready", 64'(pix_ready), 64'd1);
        pix_valid = 1'b1; pix_d = 32'h11223344;
        tick();
        chk("stream_w0", 64'(txd), {24'h0, FS, 32'h11223344});
        chk("stream_uf0", 64'(underflow), 64'd0);
        pix_valid = 1'b0; clr_underflow = 1'b1;
        tick();
        chk("stream_w1_zero", 64'(txd), {24'h0, IMG, 32'h0});
        chk("stream_uf_set_wins", 64'(underflow), 64'd1);
        pix_valid = 1'b1; clr_underflow = 1'b0; pix_d = 32'h55667788; en = 1'b0;
        tick();
        chk("stream_w2", 64'(txd), {24'h0, IMG, 32'h55667788});
        chk("stream_uf_sticky", 64'(underflow), 64'd1);
        clr_underflow = 1'b1; pix_d = 32'h99AABBCC;
        tick();
        chk("stream_w3", 64'(txd), {24'h0, FE, 32'h99AABBCC});
        chk("stream_uf_clr", 64'(underflow), 64'd0);
        chk("stream_ready_vblank", 64'(pix_ready), 64'd0);
        clr_underflow = 1'b0; pix_valid = 1'b0;

        // en dropped in row 0 of a 4-row frame
        rst = 1'b1; tick();
        rst = 1'b0; pattern_sel = 1'b1; cols = 10'd2; rows = 11'd4;
        hblank = 12'd1; vblank = 12'd1; en = 1'b1;
        tick();
        tick();
        chk("drop_fs", 64'(txd[39:32]), 64'(FS));
        en = 1'b0;
        n_ls = 0; n_le = 0; n_fe = 0; done = 1'b0;
        for (int k = 0; k < 60 && !done; k++) begin
            tick();
            if (txd[39:32] == LS) n_ls++;
            if (txd[39:32] == LE) n_le++;
            if (txd[39:32] == FE) n_fe++;
            if (!busy) done = 1'b1;
        end
        chk("drop_done", 64'(busy), 64'd0);
        chk("drop_ls", 64'(n_ls), 64'd3);
        chk("drop_le", 64'(n_le), 64'd3);
        chk("drop_fe", 64'(n_fe), 64'd1);
        chk("drop_txd", 64'(txd), {24'h0, TR, 32'h0});
        chk("drop_fc", 64'(frame_count), 64'd1);
        tick();
        chk("drop_stays_idle", 64'(busy), 64'd0);

        // Reset mid-ACTIVE
        en = 1'b1;
        tick();
        tick();
        chk("rstmid_fs", 64'(txd[39:32]), 64'(FS));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("rstmid_txd", 64'(txd), {24'h0, TR, 32'h0});
        chk("rstmid_fc", 64'(frame_count), 64'd0);
        tick();
        chk("rstmid_new_fs", 64'(txd), {24'h0, FS, 32'h03020100});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
